// File: rtl/cpu_mc_ctrl.sv
// cpu_mc_ctrl: multi-cycle execute/memory/writeback sequencer with traps and a retire counter
module cpu_mc_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int MEM_TIMEOUT = 15,
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_reg_write,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic             i_mem_to_reg,
  input  logic             i_branch,
  input  logic             i_jump,
  input  logic             i_jalr,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic             i_alu_zero,
  input  logic [XLEN-1:0]  i_pc_plus_4,
  input  logic [XLEN-1:0]  i_pc_branch,
  input  logic [4:0]       i_rd,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [2:0]       i_funct3,
  input  logic             i_mem_ready,
  input  logic [XLEN-1:0]  i_mem_rdata,
  output logic [XLEN-1:0]  o_pc_in,
  output logic             o_pc_write,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic [XLEN-1:0]  o_mem_addr,
  output logic [XLEN-1:0]  o_mem_wdata,
  output logic [2:0]       o_mem_funct3,
  output logic             o_wb_we,
  output logic [4:0]       o_wb_rd,
  output logic [XLEN-1:0]  o_wb_data,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause,
  output logic [RET_W-1:0] o_retired
);
  typedef enum logic [1:0] {EXEC, MEM, WB, TRAP} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] nxt_pc, alu_q, link_q, mdata_q;
  logic [4:0] rd_q;
  logic we_q, m2r_q, jmp_q, rd_req_q, wr_req_q, misalign, mem_op, timeout, take;
  logic [31:0] wait_cnt;
  // Next-PC selection and the EXEC/MEM exit conditions
  always_comb begin
    nxt_pc = i_jalr ? {i_alu_result[XLEN-1:1], 1'b0} :
             (i_jump | (i_branch & i_alu_zero)) ? i_pc_branch : i_pc_plus_4;
    misalign = nxt_pc[1];
    mem_op = i_mem_read | i_mem_write;
    take = (state == EXEC) & ~misalign;
    timeout = (MEM_TIMEOUT != 0) & ~i_mem_ready & (wait_cnt == 32'(MEM_TIMEOUT - 1));
  end
  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= EXEC;
    else state <= state_nx;
  end
  // Next-state logic; TRAP is absorbing until reset
  always_comb begin
    state_nx = state == EXEC ? (misalign ? TRAP : mem_op ? MEM : WB) :
               state == MEM  ? (i_mem_ready ? WB : timeout ? TRAP : MEM) :
               state == WB   ? EXEC : TRAP;
  end
  // Instruction context, memory request fields, trap cause and retire count
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_q <= '0;
      link_q <= '0;
      mdata_q <= '0;
      rd_q <= '0;
      we_q <= 1'b0;
      m2r_q <= 1'b0;
      jmp_q <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      wait_cnt <= '0;
      o_pc_in <= RESET_PC;
      o_mem_addr <= '0;
      o_mem_wdata <= '0;
      o_mem_funct3 <= 3'b010;
      o_trap_cause <= 2'd0;
      o_retired <= '0;
    end else begin
      if (take) begin
        alu_q <= i_alu_result;
        link_q <= i_pc_plus_4;
        rd_q <= i_rd;
        we_q <= i_reg_write;
        m2r_q <= i_mem_to_reg & ~(i_jump | i_jalr);
        jmp_q <= i_jump | i_jalr;
        rd_req_q <= i_mem_read;
        wr_req_q <= i_mem_write;
        o_pc_in <= nxt_pc;
      end
      if (take & mem_op) begin
        o_mem_addr <= i_alu_result;
        o_mem_wdata <= i_rs2_data;
        o_mem_funct3 <= i_funct3;
      end
      wait_cnt <= state == MEM ? wait_cnt + 32'd1 : '0;
      if (state == MEM && i_mem_ready) mdata_q <= i_mem_rdata;
      if (state != TRAP && state_nx == TRAP) o_trap_cause <= state == EXEC ? 2'd1 : 2'd2;
      if (state == WB) o_retired <= o_retired + RET_W'(1);
    end
  end
  // State-decoded strobes and writeback data selection
  always_comb begin
    o_mem_read = (state == MEM) & rd_req_q;
    o_mem_write = (state == MEM) & wr_req_q;
    o_pc_write = state == WB;
    o_wb_we = (state == WB) & we_q & (rd_q != 5'd0);
    o_wb_rd = rd_q;
    o_wb_data = m2r_q ? mdata_q : jmp_q ? link_q : alu_q;
    o_trap = state == TRAP;
  end
endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// tb_cpu_mc_ctrl: table-driven and directed checks of the multi-cycle sequencer
module tb_cpu_mc_ctrl;
  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw, m2r, br, zr, j, jr;
    logic [31:0] pc4, pcb, exp_pc;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;
  logic clk = 0, rst = 0;
  logic reg_write = 0, mem_read = 0, mem_write = 0, mem_to_reg = 0, branch = 0, jump = 0, jalr = 0;
  logic [31:0] alu_result = 0, pc_plus_4 = 0, pc_branch = 0, rs2_data = 0, mem_rdata = 0;
  logic alu_zero = 0, mem_ready = 0;
  logic [4:0] rd = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] pc_in, mem_addr, mem_wdata, wb_data, retired;
  logic pc_write, mreq_rd, mreq_wr, wb_we, trap;
  logic [2:0] mem_funct3;
  logic [4:0] wb_rd;
  logic [1:0] trap_cause;
  logic [31:0] q_pc_in, q_mem_addr, q_mem_wdata, q_wb_data;
  logic q_pc_write, q_mreq_rd, q_mreq_wr, q_wb_we, q_trap;
  logic [2:0] q_mem_funct3;
  logic [4:0] q_wb_rd;
  logic [1:0] q_trap_cause;
  logic [3:0] q_retired;
  int checks = 0, errors = 0, exp_ret = 0;
  vec_t tbl[8];
  vec_t v;

  cpu_mc_ctrl dut (
    .clk(clk), .rst(rst), .i_reg_write(reg_write), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_mem_to_reg(mem_to_reg), .i_branch(branch), .i_jump(jump), .i_jalr(jalr),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero), .i_pc_plus_4(pc_plus_4), .i_pc_branch(pc_branch),
    .i_rd(rd), .i_rs2_data(rs2_data), .i_funct3(funct3), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_pc_in(pc_in), .o_pc_write(pc_write), .o_mem_read(mreq_rd), .o_mem_write(mreq_wr),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_funct3(mem_funct3), .o_wb_we(wb_we),
    .o_wb_rd(wb_rd), .o_wb_data(wb_data), .o_trap(trap), .o_trap_cause(trap_cause), .o_retired(retired)
  );

  cpu_mc_ctrl #(.RET_W(4)) dut4 (
    .clk(clk), .rst(rst), .i_reg_write(reg_write), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_mem_to_reg(mem_to_reg), .i_branch(branch), .i_jump(jump), .i_jalr(jalr),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero), .i_pc_plus_4(pc_plus_4), .i_pc_branch(pc_branch),
    .i_rd(rd), .i_rs2_data(rs2_data), .i_funct3(funct3), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_pc_in(q_pc_in), .o_pc_write(q_pc_write), .o_mem_read(q_mreq_rd), .o_mem_write(q_mreq_wr),
    .o_mem_addr(q_mem_addr), .o_mem_wdata(q_mem_wdata), .o_mem_funct3(q_mem_funct3), .o_wb_we(q_wb_we),
    .o_wb_rd(q_wb_rd), .o_wb_data(q_wb_data), .o_trap(q_trap), .o_trap_cause(q_trap_cause), .o_retired(q_retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret();
    chk("retired", retired, exp_ret);
    chk("retired_w4", {28'd0, q_retired}, exp_ret % 16);
  endtask

  task automatic chk_reset();
    chk("rst_pc_in", pc_in, 32'h0);
    chk("rst_pc_write", {31'd0, pc_write}, 0);
    chk("rst_mem_read", {31'd0, mreq_rd}, 0);
    chk("rst_mem_write", {31'd0, mreq_wr}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_funct3", {29'd0, mem_funct3}, 32'd2);
    chk("rst_wb_we", {31'd0, wb_we}, 0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_trap", {31'd0, trap}, 0);
    chk("rst_cause", {30'd0, trap_cause}, 0);
    chk_ret();
  endtask

  task automatic drive(input vec_t x, input logic mr, input logic mw, input logic [31:0] rs2, input logic [2:0] f3);
    alu_result = x.alu; rd = x.rd; reg_write = x.rw; mem_to_reg = x.m2r;
    branch = x.br; alu_zero = x.zr; jump = x.j; jalr = x.jr;
    pc_plus_4 = x.pc4; pc_branch = x.pcb;
    mem_read = mr; mem_write = mw; rs2_data = rs2; funct3 = f3; mem_ready = 0;
  endtask

  task automatic run_vec(input vec_t x, input int idx);
    drive(x, 0, 0, 0, 3'b010);
    tick();
    chk($sformatf("v%0d_pc_write", idx), {31'd0, pc_write}, 1);
    chk($sformatf("v%0d_pc_in", idx), pc_in, x.exp_pc);
    chk($sformatf("v%0d_wb_we", idx), {31'd0, wb_we}, {31'd0, x.exp_we});
    chk($sformatf("v%0d_wb_rd", idx), {27'd0, wb_rd}, {27'd0, x.rd});
    chk($sformatf("v%0d_wb_data", idx), wb_data, x.exp_data);
    chk($sformatf("v%0d_no_mem", idx), {31'd0, mreq_rd | mreq_wr}, 0);
    tick();
    exp_ret++;
    chk($sformatf("v%0d_pc_write_off", idx), {31'd0, pc_write | wb_we}, 0);
    chk_ret();
  endtask

  initial begin
    tbl[0] = '{32'h5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 32'h4, 1'b1, 32'h5};
    tbl[1] = '{32'h77, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 32'h8, 1'b0, 32'h77};
    tbl[2] = '{32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC, 32'h40, 32'h40, 1'b0, 32'h0};
    tbl[3] = '{32'h1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h80, 32'h44, 1'b0, 32'h1};
    tbl[4] = '{32'h101, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h24, 32'h0, 32'h100, 1'b1, 32'h24};
    tbl[5] = '{32'h9, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'h200, 32'h200, 1'b1, 32'h104};
    tbl[6] = '{32'h30, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h28, 32'h500, 32'h30, 1'b1, 32'h28};
    tbl[7] = '{32'hFFFFFFFF, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h34, 32'h0, 32'h34, 1'b1, 32'hFFFFFFFF};
    rst = 0;
    tick();
    tick();
    chk_reset();
    rst = 1;
    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    v = '{32'h1000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h38, 32'h0, 32'h0, 1'b0, 32'h0};
    drive(v, 1, 0, 32'h55, 3'b100);
    tick();
    alu_result = 32'h9999;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ld_req_%0d", i), {31'd0, mreq_rd}, 1);
      chk($sformatf("ld_addr_%0d", i), mem_addr, 32'h1000);
      chk($sformatf("ld_quiet_%0d", i), {31'd0, pc_write | wb_we}, 0);
      tick();
    end
    chk("ld_req_3", {31'd0, mreq_rd}, 1);
    chk("ld_funct3", {29'd0, mem_funct3}, 32'd4);
    mem_ready = 1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ready = 0;
    mem_rdata = 0;
    chk("ld_req_off", {31'd0, mreq_rd}, 0);
    chk("ld_pc_write", {31'd0, pc_write}, 1);
    chk("ld_pc_in", pc_in, 32'h38);
    chk("ld_wb_we", {31'd0, wb_we}, 1);
    chk("ld_wb_rd", {27'd0, wb_rd}, 32'd7);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    tick();
    exp_ret++;
    chk_ret();

    v = '{32'h2000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0, 32'h0};
    drive(v, 0, 1, 32'hCAFE, 3'b001);
    tick();
    chk("st_wdata", mem_wdata, 32'hCAFE);
    chk("st_addr", mem_addr, 32'h2000);
    for (int i = 0; i < 14; i++) tick();
    chk("st_last_wait_req", {31'd0, mreq_wr}, 1);
    chk("st_last_wait_trap", {31'd0, trap}, 0);
    mem_ready = 1;
    tick();
    mem_ready = 0;
    chk("st_ready_wins_pcw", {31'd0, pc_write}, 1);
    chk("st_ready_wins_trap", {31'd0, trap}, 0);
    chk("st_req_off", {31'd0, mreq_wr}, 0);
    tick();
    exp_ret++;
    chk_ret();

    for (int i = 0; i < 6; i++) begin
      v = '{32'(i), 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 32'h40 + 32'(4 * i), 1'b1, 32'(i)};
      run_vec(v, 10 + i);
    end
    chk("wrap_w4", {28'd0, q_retired}, 0);
    chk("wrap_w32", retired, 32'd16);

    v = '{32'h3000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h58, 32'h0, 32'h0, 1'b0, 32'h0};
    drive(v, 0, 1, 32'h1234, 3'b010);
    tick();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("to_req_%0d", i), {31'd0, mreq_wr}, 1);
      tick();
    end
    chk("to_trap", {31'd0, trap}, 1);
    chk("to_cause", {30'd0, trap_cause}, 32'd2);
    chk("to_req_off", {31'd0, mreq_wr}, 0);
    chk("to_quiet", {31'd0, pc_write | wb_we}, 0);
    tick();
    chk("to_sticky", {31'd0, trap}, 1);
    chk("to_sticky_cause", {30'd0, trap_cause}, 32'd2);
    chk_ret();

    rst = 0;
    tick();
    rst = 1;
    exp_ret = 0;
    chk_reset();

    v = '{32'h4000, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 32'h0};
    drive(v, 1, 0, 32'h0, 3'b010);
    tick();
    chk("mid_req_on", {31'd0, mreq_rd}, 1);
    rst = 0;
    tick();
    rst = 1;
    chk("mid_req_dropped", {31'd0, mreq_rd}, 0);
    chk("mid_pc_in", pc_in, 32'h0);
    chk("mid_funct3", {29'd0, mem_funct3}, 32'd2);

    v = '{32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h102, 32'h0, 1'b0, 32'h0};
    drive(v, 0, 0, 32'h0, 3'b010);
    tick();
    chk("mis_trap", {31'd0, trap}, 1);
    chk("mis_cause", {30'd0, trap_cause}, 32'd1);
    chk("mis_wb_we", {31'd0, wb_we}, 0);
    chk("mis_pc_write", {31'd0, pc_write}, 0);
    tick();
    chk("mis_sticky", {31'd0, trap}, 1);
    chk("mis_quiet", {31'd0, pc_write | wb_we | mreq_rd | mreq_wr}, 0);
    chk("mis_pc_in", pc_in, 32'h0);
    chk_ret();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_mc_ctrl.md
Name: cpu_mc_ctrl

Overview:
Parametrised multi-cycle sequencer that replaces the fixed two-phase execute/writeback FSM in the CPU top. It drives PC update, data-memory requests and register-file writeback from decoded control signals. It adds JAL/JALR support, variable-latency memory with a ready handshake and a timeout, misaligned-target trapping, and a retired-instruction counter. It sits between the control unit/ALU/PC adder and the PC, data memory and register file.

Parameters:
XLEN, 32, datapath width of PC, ALU result, memory address and data.
RESET_PC, 0, PC value loaded on reset.
MEM_TIMEOUT, 15, max cycles waiting for mem_ready before trap; 0 disables timeout.
RET_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low.
i_reg_write  in  1  decoded RegWrite.
i_mem_read  in  1  decoded MemRead.
i_mem_write  in  1  decoded MemWrite.
i_mem_to_reg  in  1  decoded MemToReg.
i_branch  in  1  conditional branch.
i_jump  in  1  JAL.
i_jalr  in  1  JALR.
i_alu_result  in  XLEN  ALU output (JALR target before LSB clear).
i_alu_zero  in  1  branch condition.
i_pc_plus_4  in  XLEN  current PC + 4.
i_pc_branch  in  XLEN  PC + imm (branch/JAL target).
i_rd  in  5  destination register.
i_rs2_data  in  XLEN  store data.
i_funct3  in  3  memory access size/sign.
i_mem_ready  in  1  memory completion strobe.
i_mem_rdata  in  XLEN  memory read data, valid when i_mem_ready=1.
o_pc_in  out  XLEN  next PC.
o_pc_write  out  1  one-cycle PC load strobe.
o_mem_read  out  1  read request, held until accepted.
o_mem_write  out  1  write request, held until accepted.
o_mem_addr  out  XLEN  memory address.
o_mem_wdata  out  XLEN  store data.
o_mem_funct3  out  3  access size.
o_wb_we  out  1  register write enable, one cycle.
o_wb_rd  out  5  writeback register.
o_wb_data  out  XLEN  writeback data.
o_trap  out  1  sticky fault flag.
o_trap_cause  out  2  0 none, 1 misaligned target, 2 memory timeout.
o_retired  out  RET_W  retired-instruction count.

Behaviour:
- States: EXEC, MEM, WB, TRAP. On rst=0 at posedge: state=EXEC; o_pc_in=RESET_PC; all other outputs 0, except o_mem_funct3=3'b010. Reset mid-MEM drops the request in the same edge.
- EXEC (one cycle): latch i_alu_result, i_rd, i_reg_write, i_mem_to_reg, i_pc_plus_4.
  - Next PC priority: i_jalr -> {i_alu_result[XLEN-1:1],1'b0}; else i_jump -> i_pc_branch; else i_branch&i_alu_zero -> i_pc_branch; else i_pc_plus_4.
  - If next PC[1]=1: go to TRAP with cause 1. No writeback and no PC write occur.
  - Link value: for JAL/JALR, writeback data is i_pc_plus_4, and i_mem_to_reg is ignored.
  - If i_mem_read|i_mem_write: drive o_mem_addr/wdata/funct3 and assert the request; go to MEM. Otherwise go to WB.
- MEM: hold request and address stable until i_mem_ready=1. On that cycle, capture i_mem_rdata, deassert the request on the next edge and go to WB.
  - A wait counter increments each MEM cycle without ready. If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT: deassert the request and go to TRAP with cause 2.
  - A ready arriving on the same cycle the count hits the limit wins (no trap).
- WB (one cycle):
  - o_wb_we = saved RegWrite & (rd≠0).
  - o_wb_data = mem data if MemToReg, else link value if jump, else ALU result.
  - o_pc_write=1 for exactly one cycle; o_retired increments by 1, wrapping modulo 2^RET_W. Go to EXEC.
- o_wb_we and o_pc_write are 0 in every state other than WB.
- TRAP: terminal until reset. o_trap=1, cause held, no memory, PC or writeback activity.
- Latency: non-memory instruction takes 2 cycles; memory instruction takes 3 + wait cycles.

Test Plan:
- ADD-type sequence from RESET_PC=0: i_alu_result=0x5, i_rd=3, i_reg_write=1 -> WB cycle 2 shows o_wb_rd=3, o_wb_data=0x5, o_pc_in=0x4, o_pc_write=1; o_retired=1.
- Load with i_mem_ready delayed 3 cycles, i_mem_rdata=0xDEADBEEF -> request held 4 cycles with a stable address; o_wb_data=0xDEADBEEF; instruction takes 6 cycles.
- JALR with i_alu_result=0x101, i_pc_plus_4=0x24, i_rd=1 -> o_pc_in=0x100, o_wb_data=0x24.
- JAL to i_pc_branch=0x102 -> TRAP, o_trap_cause=1, no o_wb_we, no o_pc_write.
- Store with i_mem_ready never asserted, MEM_TIMEOUT=15 -> o_trap_cause=2 after 15 MEM cycles, o_mem_write=0. Then assert rst=0 for one edge -> all outputs return to reset values, o_pc_in=RESET_PC.
- Write to rd=0 with i_reg_write=1 -> o_wb_we stays 0; set RET_W=4 and retire 16 instructions -> o_retired wraps to 0.
